// File: rtl/mux_4x1_dataflow_pkg.sv
// Shared constants and select codes for the 4:1 single-bit multiplexer.
package mux_4x1_dataflow_pkg;

    localparam int SEL_W = 2;
    localparam int N_IN  = 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_IN0 = 2'b00,
        SEL_IN1 = 2'b01,
        SEL_IN2 = 2'b10,
        SEL_IN3 = 2'b11
    } sel_e;

endpackage

// File: rtl/mux_4x1_dataflow_if.sv
// Bus bundle between a 4-bit status source and the single-bit consumer of the mux.
interface mux_4x1_dataflow_if;
    import mux_4x1_dataflow_pkg::*;

    logic [N_IN-1:0]  data_in;
    logic [SEL_W-1:0] sel;
    logic             out;
    logic             out_q;
    logic [SEL_W-1:0] sel_q;

    modport master (
        output data_in,
        output sel,
        input  out,
        input  out_q,
        input  sel_q
    );

    modport slave (
        input  data_in,
        input  sel,
        output out,
        output out_q,
        output sel_q
    );

endinterface

// File: rtl/mux_4x1_dataflow_mux4_comb.sv
// Pure dataflow 4:1 bit selector; no clock, no state.
module mux4_comb
    import mux_4x1_dataflow_pkg::*;
(
    input  logic [N_IN-1:0]  data_in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    // Sum of products; an unknown select propagates X through the compares.
    assign out = (data_in[0] & (sel == SEL_IN0))
               | (data_in[1] & (sel == SEL_IN1))
               | (data_in[2] & (sel == SEL_IN2))
               | (data_in[3] & (sel == SEL_IN3));

endmodule

// File: rtl/mux_4x1_dataflow.sv
// 4:1 bit mux: combinational out plus a registered copy of the result and select.
module mux_4x1_dataflow
    import mux_4x1_dataflow_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mux_4x1_dataflow_if.slave  bus
);

    logic             out_c;
    logic             out_d;
    logic             out_q;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] sel_q;

    mux4_comb u_mux4_comb (
        .data_in (bus.data_in),
        .sel     (bus.sel),
        .out     (out_c)
    );

    assign bus.out = out_c;

    always_comb begin
        out_d = out_c;
        sel_d = bus.sel;
    end

    // Register stage: reset clears asynchronously and dominates a coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 1'b0;
            sel_q <= SEL_IN0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

    assign bus.out_q = out_q;
    assign bus.sel_q = sel_q;

endmodule

// File: tb/tb_mux_4x1_dataflow.sv
// Directed bench for mux_4x1_dataflow: combinational sweep, registered path and reset.
module tb_mux_4x1_dataflow;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mux_4x1_dataflow_if bus ();

    mux_4x1_dataflow dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Directed one-hot / pattern vectors: expected bit for sel = 0,1,2,3.
    logic [3:0] vec_data [4] = '{4'b0100, 4'b1011, 4'b1010, 4'b0110};
    logic [3:0] vec_exp  [4] = '{4'b0100, 4'b1011, 4'b1010, 4'b0110};
    // Registered-path vectors with hand-picked results.
    logic [3:0] reg_data [4] = '{4'b0110, 4'b0110, 4'b0001, 4'b1110};
    logic [1:0] reg_sel  [4] = '{2'd1,    2'd3,    2'd0,    2'd0};
    logic       reg_exp  [4] = '{1'b1,    1'b0,    1'b1,    1'b0};

    initial begin
        bus.data_in = 4'b0000;
        bus.sel     = 2'b00;

        // Clockless exhaustive sweep, clk and rst held low.
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 4; s++) begin
                logic [3:0] dv;
                logic       ev;
                dv = 4'(d);
                ev = dv[s];
                bus.data_in = dv;
                bus.sel     = 2'(s);
                #5;
                check("sweep", 4'(bus.out), 4'(ev));
            end
        end

        // Directed patterns.
        for (int v = 0; v < 4; v++) begin
            for (int s = 0; s < 4; s++) begin
                logic [3:0] ew;
                ew = vec_exp[v];
                bus.data_in = vec_data[v];
                bus.sel     = 2'(s);
                #5;
                check("pattern", 4'(bus.out), 4'(ew[s]));
            end
        end
        bus.data_in = 4'b1010; bus.sel = 2'b01; #5;
        check("ex_1010_s1", 4'(bus.out), 4'd1);
        bus.sel = 2'b10; #5;
        check("ex_1010_s2", 4'(bus.out), 4'd0);

        // Asynchronous reset with no clock running.
        rst = 1'b1;
        #1;
        check("rst_noclk_out_q", 4'(bus.out_q), 4'd0);
        check("rst_noclk_sel_q", 4'(bus.sel_q), 4'd0);

        // Reset held across rising edges with all inputs high.
        clk_en = 1'b1;
        bus.data_in = 4'b1111;
        bus.sel     = 2'b00;
        @(posedge clk); #1;
        check("rst_edge_out_q", 4'(bus.out_q), 4'd0);
        check("rst_edge_sel_q", 4'(bus.sel_q), 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("release_out_q", 4'(bus.out_q), 4'd1);
        check("release_sel_q", 4'(bus.sel_q), 4'd0);

        // Registered path: one-cycle latency, combinational out immediate.
        @(negedge clk);
        bus.data_in = 4'b1000;
        bus.sel     = 2'b11;
        @(posedge clk); #1;
        check("reg_out_q", 4'(bus.out_q), 4'd1);
        check("reg_sel_q", 4'(bus.sel_q), 4'd3);
        @(negedge clk);
        bus.sel = 2'b00;
        #1;
        check("midcycle_out", 4'(bus.out), 4'd0);
        check("midcycle_out_q", 4'(bus.out_q), 4'd1);
        check("midcycle_sel_q", 4'(bus.sel_q), 4'd3);
        @(posedge clk); #1;
        check("next_out_q", 4'(bus.out_q), 4'd0);
        check("next_sel_q", 4'(bus.sel_q), 4'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.data_in = reg_data[i];
            bus.sel     = reg_sel[i];
            @(posedge clk); #1;
            check("vec_out_q", 4'(bus.out_q), 4'(reg_exp[i]));
            check("vec_sel_q", 4'(bus.sel_q), 4'(reg_sel[i]));
        end

        // Async reset between edges while out_q is 1.
        @(negedge clk);
        bus.data_in = 4'b1000;
        bus.sel     = 2'b11;
        @(posedge clk); #1;
        check("pre_rst_out_q", 4'(bus.out_q), 4'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_q", 4'(bus.out_q), 4'd0);
        check("async_sel_q", 4'(bus.sel_q), 4'd0);
        check("async_out", 4'(bus.out), 4'd1);
        @(posedge clk); #1;
        check("held_out_q", 4'(bus.out_q), 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_out_q", 4'(bus.out_q), 4'd1);
        check("post_sel_q", 4'(bus.sel_q), 4'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
